// File: rtl/render_pkg.sv
// Shared types and constants for the polygon scene buffer
// and the render stage that consumes its front bank.
package render_pkg;

  localparam int COORD_W = 32;
  localparam int MIN_POLY_VERTICES = 3;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef enum logic {
    LOAD,
    PENDING
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/polygon_scene_buffer_if.sv
// Vertex stream handshake between the scene source and the
// polygon scene buffer.
interface polygon_scene_buffer_if
  import render_pkg::*;
#(
  parameter int COORD_WIDTH = COORD_W
);

  logic                          vert_valid_in;
  logic                          vert_ready_out;
  logic signed [COORD_WIDTH-1:0] vert_x_in;
  logic signed [COORD_WIDTH-1:0] vert_y_in;
  logic                          vert_last_in;

  modport master (
    output vert_valid_in,
    output vert_x_in,
    output vert_y_in,
    output vert_last_in,
    input  vert_ready_out
  );

  modport slave (
    input  vert_valid_in,
    input  vert_x_in,
    input  vert_y_in,
    input  vert_last_in,
    output vert_ready_out
  );

endinterface

// File: rtl/polygon_scene_buffer_bank.sv
// One bank of polygon storage: vertex and side-count write
// ports with the whole table exposed as flat read outputs.
module polygon_bank
  import render_pkg::*;
#(
  parameter int NV  = 8,
  parameter int NP  = 4,
  parameter int CW  = COORD_W,
  parameter int VW  = 4,
  localparam int PIW = idx_w(NP),
  localparam int VIW = idx_w(NV)
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         v_we,
  input  logic                         n_we,
  input  logic [PIW-1:0]               w_poly,
  input  logic [VIW-1:0]               w_vert,
  input  logic [CW-1:0]                w_x,
  input  logic [CW-1:0]                w_y,
  input  logic [VW-1:0]                w_ns,
  output logic [NP-1:0][NV-1:0][CW-1:0] xs_o,
  output logic [NP-1:0][NV-1:0][CW-1:0] ys_o,
  output logic [NP-1:0][VW-1:0]         ns_o
);

  logic [NP-1:0][NV-1:0][CW-1:0] xs_q, xs_d;
  logic [NP-1:0][NV-1:0][CW-1:0] ys_q, ys_d;
  logic [NP-1:0][VW-1:0]         ns_q, ns_d;

  always_comb begin
    xs_d = xs_q;
    ys_d = ys_q;
    ns_d = ns_q;
    if (v_we) begin
      xs_d[w_poly][w_vert] = w_x;
      ys_d[w_poly][w_vert] = w_y;
    end
    if (n_we) begin
      ns_d[w_poly] = w_ns;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      xs_q <= '0;
      ys_q <= '0;
      ns_q <= '0;
    end else begin
      xs_q <= xs_d;
      ys_q <= ys_d;
      ns_q <= ns_d;
    end
  end

  assign xs_o = xs_q;
  assign ys_o = ys_q;
  assign ns_o = ns_q;

endmodule

// File: rtl/polygon_scene_buffer.sv
// Double-buffered polygon table fed by a vertex stream; the
// front bank swaps only on a frame start after a commit.
module polygon_scene_buffer
  import render_pkg::*;
#(
  parameter int MAX_NUM_VERTICES       = 8,
  parameter int MAX_POLYGONS_ON_SCREEN = 4,
  parameter int COORD_WIDTH            = COORD_W,
  localparam int NV  = MAX_NUM_VERTICES,
  localparam int NP  = MAX_POLYGONS_ON_SCREEN,
  localparam int CW  = COORD_WIDTH,
  localparam int VW  = $clog2(NV + 1),
  localparam int PW  = $clog2(NP + 1),
  localparam int PIW = idx_w(NP),
  localparam int VIW = idx_w(NV)
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  polygon_scene_buffer_if.slave         vert_if,
  input  logic                          commit_in,
  input  logic                          frame_start_in,
  output logic [NP-1:0][NV-1:0][CW-1:0] polygons_xs_out,
  output logic [NP-1:0][NV-1:0][CW-1:0] polygons_ys_out,
  output logic [NP-1:0][VW-1:0]         polygons_num_sides_out,
  output logic [PW-1:0]                 polygons_on_screen_out,
  output logic                          swap_out,
  output logic                          vert_overflow_out,
  output logic                          poly_overflow_out,
  output logic                          poly_dropped_out
);

  state_e        state_q, state_d;
  logic          front_q, front_d;
  logic [VW-1:0] vidx_q, vidx_d;
  logic [PW-1:0] pidx_q, pidx_d;
  logic [PW-1:0] on_q, on_d;
  logic          ready_q, ready_d;
  logic          swap_q, swap_d;
  logic          vovf_q, vovf_d;
  logic          povf_q, povf_d;
  logic          pdrop_q, pdrop_d;

  logic          hs;
  logic          full;
  logic          room;
  logic          store;
  logic          wr_ns;
  logic [VW-1:0] cnt;

  logic [NP-1:0][NV-1:0][CW-1:0] xs_b [2];
  logic [NP-1:0][NV-1:0][CW-1:0] ys_b [2];
  logic [NP-1:0][VW-1:0]         ns_b [2];
  logic [NP-1:0][VW-1:0]         ns_f;

  assign hs   = vert_if.vert_valid_in & ready_q;
  assign full = (pidx_q == PW'(NP));
  assign room = (vidx_q != VW'(NV));

  always_comb begin
    state_d = state_q;
    front_d = front_q;
    vidx_d  = vidx_q;
    pidx_d  = pidx_q;
    on_d    = on_q;
    swap_d  = 1'b0;
    vovf_d  = vovf_q;
    povf_d  = povf_q;
    pdrop_d = pdrop_q;
    store   = 1'b0;
    wr_ns   = 1'b0;
    cnt     = vidx_q;
    unique case (state_q)
      LOAD: begin
        if (hs) begin
          if (full) begin
            povf_d = 1'b1;
          end else if (!room) begin
            vovf_d = 1'b1;
          end else begin
            store  = 1'b1;
            vidx_d = vidx_q + 1'b1;
          end
          if (vert_if.vert_last_in) begin
            cnt    = vidx_q + VW'(store);
            vidx_d = '0;
            if (!full) begin
              if (cnt >= VW'(MIN_POLY_VERTICES)) begin
                wr_ns  = 1'b1;
                pidx_d = pidx_q + 1'b1;
              end else begin
                pdrop_d = 1'b1;
              end
            end
          end
        end
        // a polygon still open at commit never reaches the table
        if (commit_in) begin
          state_d = PENDING;
          if (vidx_d != '0) begin
            vidx_d  = '0;
            pdrop_d = 1'b1;
          end
        end
      end
      PENDING: begin
        if (frame_start_in) begin
          state_d = LOAD;
          front_d = ~front_q;
          on_d    = pidx_q;
          swap_d  = 1'b1;
          vidx_d  = '0;
          pidx_d  = '0;
          vovf_d  = 1'b0;
          povf_d  = 1'b0;
          pdrop_d = 1'b0;
        end
      end
    endcase
    ready_d = (state_d == LOAD);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= LOAD;
      front_q <= 1'b0;
      vidx_q  <= '0;
      pidx_q  <= '0;
      on_q    <= '0;
      ready_q <= 1'b0;
      swap_q  <= 1'b0;
      vovf_q  <= 1'b0;
      povf_q  <= 1'b0;
      pdrop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      front_q <= front_d;
      vidx_q  <= vidx_d;
      pidx_q  <= pidx_d;
      on_q    <= on_d;
      ready_q <= ready_d;
      swap_q  <= swap_d;
      vovf_q  <= vovf_d;
      povf_q  <= povf_d;
      pdrop_q <= pdrop_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    polygon_bank #(
      .NV (NV),
      .NP (NP),
      .CW (CW),
      .VW (VW)
    ) u_bank (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .v_we   (store && (front_q != b[0])),
      .n_we   (wr_ns && (front_q != b[0])),
      .w_poly (pidx_q[PIW-1:0]),
      .w_vert (vidx_q[VIW-1:0]),
      .w_x    (vert_if.vert_x_in),
      .w_y    (vert_if.vert_y_in),
      .w_ns   (cnt),
      .xs_o   (xs_b[b]),
      .ys_o   (ys_b[b]),
      .ns_o   (ns_b[b])
    );
  end

  assign polygons_xs_out = front_q ? xs_b[1] : xs_b[0];
  assign polygons_ys_out = front_q ? ys_b[1] : ys_b[0];
  assign ns_f            = front_q ? ns_b[1] : ns_b[0];

  // slots past the count hold an older scene; hide them
  always_comb begin
    for (int p = 0; p < NP; p++) begin
      polygons_num_sides_out[p] =
        (PW'(p) < on_q) ? ns_f[p] : '0;
    end
  end

  assign polygons_on_screen_out = on_q;
  assign swap_out               = swap_q;
  assign vert_overflow_out      = vovf_q;
  assign poly_overflow_out      = povf_q;
  assign poly_dropped_out       = pdrop_q;
  assign vert_if.vert_ready_out = ready_q;

endmodule

// File: tb/tb_polygon_scene_buffer.sv
// Scoreboard bench: scenes queue their expected front bank,
// a monitor compares it whenever swap_out pulses.
module tb_polygon_scene_buffer;
  import render_pkg::*;

  localparam int NV = 8;
  localparam int NP = 4;
  localparam int CW = 32;

  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic commit_in = 1'b0;
  logic frame_start_in = 1'b0;

  logic [NP-1:0][NV-1:0][CW-1:0] xs, ys;
  logic [NP-1:0][3:0] ns;
  logic [2:0] on;
  logic swap, vo, po, pd;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int on;
    logic [3:0][3:0] ns;
    logic [2:0] fl;
    logic [2:0] fm;
    int nc;
    logic [3:0][1:0] cp;
    logic [3:0][2:0] cv;
    logic [3:0][31:0] cx;
    logic [3:0][31:0] cy;
  } exp_t;

  exp_t exp_q[$];
  exp_t ex;

  polygon_scene_buffer_if #(.COORD_WIDTH(CW)) vif();

  polygon_scene_buffer #(
    .MAX_NUM_VERTICES(NV),
    .MAX_POLYGONS_ON_SCREEN(NP),
    .COORD_WIDTH(CW)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .vert_if(vif),
    .commit_in(commit_in),
    .frame_start_in(frame_start_in),
    .polygons_xs_out(xs),
    .polygons_ys_out(ys),
    .polygons_num_sides_out(ns),
    .polygons_on_screen_out(on),
    .swap_out(swap),
    .vert_overflow_out(vo),
    .poly_overflow_out(po),
    .poly_dropped_out(pd)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic newexp(input int n, input logic [15:0] nsv,
                        input logic [2:0] fl, input logic [2:0] fm);
    ex.on = n;
    ex.ns = nsv;
    ex.fl = fl;
    ex.fm = fm;
    ex.nc = 0;
    ex.cp = '0;
    ex.cv = '0;
    ex.cx = '0;
    ex.cy = '0;
  endtask

  task automatic put(input int p, input int v,
                     input int x, input int y);
    ex.cp[ex.nc] = 2'(p);
    ex.cv[ex.nc] = 3'(v);
    ex.cx[ex.nc] = x;
    ex.cy[ex.nc] = y;
    ex.nc++;
  endtask

  task automatic send(input int x, input int y, input bit last);
    vif.vert_valid_in = 1'b1;
    vif.vert_x_in = x;
    vif.vert_y_in = y;
    vif.vert_last_in = last;
    @(posedge clk_in);
    #1;
    vif.vert_valid_in = 1'b0;
    vif.vert_last_in = 1'b0;
  endtask

  task automatic commit();
    commit_in = 1'b1;
    @(posedge clk_in);
    #1;
    commit_in = 1'b0;
  endtask

  task automatic frame();
    frame_start_in = 1'b1;
    @(posedge clk_in);
    #1;
    frame_start_in = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    chk("swap_one_cycle", swap, 0);
  endtask

  initial begin : monitor
    exp_t e;
    logic [2:0] pf;
    pf = '0;
    forever begin
      @(negedge clk_in);
      if (rst_in && swap) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_swap", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("on_screen", on, e.on);
          for (int p = 0; p < NP; p++)
            chk($sformatf("num_sides[%0d]", p), ns[p], e.ns[p]);
          for (int i = 0; i < e.nc; i++) begin
            chk($sformatf("xs[%0d][%0d]", e.cp[i], e.cv[i]),
                xs[e.cp[i]][e.cv[i]], e.cx[i]);
            chk($sformatf("ys[%0d][%0d]", e.cp[i], e.cv[i]),
                ys[e.cp[i]][e.cv[i]], e.cy[i]);
          end
          chk("flags_pending", pf & e.fm, e.fl & e.fm);
          chk("flags_after_swap", {vo, po, pd}, 0);
        end
      end
      pf = {vo, po, pd};
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    vif.vert_valid_in = 1'b0;
    vif.vert_x_in = '0;
    vif.vert_y_in = '0;
    vif.vert_last_in = 1'b0;
    #2;
    chk("rst_ready", vif.vert_ready_out, 0);
    chk("rst_on", on, 0);
    chk("rst_ns", ns, 0);
    chk("rst_swap", swap, 0);
    chk("rst_flags", {vo, po, pd}, 0);
    chk("rst_xs00", xs[0][0], 0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("ready_before_clk", vif.vert_ready_out, 0);
    @(negedge clk_in);
    chk("ready_after_release", vif.vert_ready_out, 1);

    // square; a frame start while loading must not swap
    newexp(1, {4'd0, 4'd0, 4'd0, 4'd4}, 3'b000, 3'b111);
    put(0, 0, 100, 100);
    put(0, 1, 200, 100);
    put(0, 2, 200, 200);
    put(0, 3, 100, 200);
    send(100, 100, 0);
    send(200, 100, 0);
    send(200, 200, 0);
    send(100, 200, 1);
    frame_start_in = 1'b1;
    @(posedge clk_in);
    #1;
    frame_start_in = 1'b0;
    @(negedge clk_in);
    chk("load_frame_on", on, 0);
    chk("load_frame_ns0", ns[0], 0);
    exp_q.push_back(ex);
    chk("ready_before_commit", vif.vert_ready_out, 1);
    commit();
    @(negedge clk_in);
    chk("ready_pending", vif.vert_ready_out, 0);
    chk("hold_on_s1", on, 0);
    frame();

    // nine vertices into one polygon
    newexp(1, {4'd0, 4'd0, 4'd0, 4'd8}, 3'b100, 3'b111);
    put(0, 0, 0, 1);
    put(0, 1, 10, 11);
    put(0, 7, 70, 71);
    exp_q.push_back(ex);
    for (int i = 0; i < 9; i++)
      send(i * 10, i * 10 + 1, i == 8);
    commit();
    frame();

    // five triangles into a four-slot table
    newexp(4, {4'd3, 4'd3, 4'd3, 4'd3}, 3'b010, 3'b110);
    put(0, 1, 1, 1);
    put(1, 2, 102, 12);
    put(3, 0, 300, 30);
    put(3, 2, 302, 32);
    exp_q.push_back(ex);
    for (int k = 0; k < 5; k++)
      for (int j = 0; j < 3; j++)
        send(k * 100 + j, k * 10 + j, j == 2);
    commit();
    frame();

    // degenerate polygon then a triangle
    newexp(1, {4'd0, 4'd0, 4'd0, 4'd3}, 3'b001, 3'b111);
    put(0, 0, 300, 300);
    put(0, 1, 400, 100);
    put(0, 2, 500, 300);
    exp_q.push_back(ex);
    send(7, 7, 0);
    send(8, 8, 1);
    send(300, 300, 0);
    send(400, 100, 0);
    send(500, 300, 1);
    commit();
    frame();

    // commit with a beat in flight; stale slots must read 0
    newexp(1, {4'd0, 4'd0, 4'd0, 4'd3}, 3'b001, 3'b111);
    put(0, 0, -5, -6);
    put(0, 1, 10, -20);
    put(0, 2, 0, 30);
    exp_q.push_back(ex);
    send(-5, -6, 0);
    send(10, -20, 0);
    send(0, 30, 1);
    vif.vert_valid_in = 1'b1;
    vif.vert_x_in = 99;
    vif.vert_y_in = 99;
    vif.vert_last_in = 1'b0;
    commit();
    @(negedge clk_in);
    chk("ready_held_valid", vif.vert_ready_out, 0);
    chk("hold_on_s5", on, 1);
    chk("hold_ns0_s5", ns[0], 3);
    chk("hold_xs00_s5", xs[0][0], 300);
    @(negedge clk_in);
    chk("ready_held_valid2", vif.vert_ready_out, 0);
    vif.vert_valid_in = 1'b0;
    frame();

    // reset while pending
    send(1, 1, 0);
    send(2, 2, 1);
    commit();
    @(negedge clk_in);
    chk("pd_visible_pending", pd, 1);
    rst_in = 1'b0;
    #1;
    chk("midrst_on", on, 0);
    chk("midrst_ns", ns, 0);
    chk("midrst_xs00", xs[0][0], 0);
    chk("midrst_flags", {vo, po, pd}, 0);
    chk("midrst_ready", vif.vert_ready_out, 0);
    chk("midrst_swap", swap, 0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("midrst_ready_pre", vif.vert_ready_out, 0);
    @(negedge clk_in);
    chk("midrst_ready_post", vif.vert_ready_out, 1);
    chk("midrst_on_post", on, 0);

    // loading works again after reset
    newexp(1, {4'd0, 4'd0, 4'd0, 4'd4}, 3'b000, 3'b111);
    put(0, 0, 100, 100);
    put(0, 2, 200, 200);
    exp_q.push_back(ex);
    send(100, 100, 0);
    send(200, 100, 0);
    send(200, 200, 0);
    send(100, 200, 1);
    commit();
    frame();

    repeat (3) @(negedge clk_in);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
